// File: rtl/id_ctrl_pipe.sv
// RV32I decode stage: combinational decode of the fetched instruction feeding a registered
// ID/EX control register, with a shift-register load-use scoreboard and a saturating stall counter.
module id_ctrl_pipe #(
  parameter int unsigned LOAD_USE_LAT = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_inst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_ex_ready,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [31:0]      o_inst,
  output logic [5:0]       o_format,
  output logic [2:0]       o_opsel,
  output logic             o_sub,
  output logic             o_unsigned,
  output logic             o_arith,
  output logic             o_rd_wen,
  output logic             o_mem_wen,
  output logic             o_mem_to_reg,
  output logic             o_alu_src_2,
  output logic             o_alu_src1,
  output logic             o_u_load0,
  output logic [1:0]       o_sbhw_sel,
  output logic [1:0]       o_lbhw_sel,
  output logic             o_l_unsigned,
  output logic             o_is_branch,
  output logic             o_is_jal,
  output logic             o_is_jalr,
  output logic             o_is_jump,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_JALR   = 7'b1100111,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef struct packed {
    logic [5:0] format;
    logic [2:0] opsel;
    logic       sub;
    logic       uns;
    logic       arith;
    logic       rd_wen;
    logic       mem_wen;
    logic       mem_to_reg;
    logic       alu_src_2;
    logic       alu_src1;
    logic       u_load0;
    logic [1:0] sbhw_sel;
    logic [1:0] lbhw_sel;
    logic       l_unsigned;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_jump;
    logic       illegal;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;

  assign opcode = i_inst[6:0];
  assign funct3 = i_inst[14:12];
  assign funct7 = i_inst[31:25];
  assign rd     = i_inst[11:7];
  assign rs1    = i_inst[19:15];
  assign rs2    = i_inst[24:20];

  logic is_r, is_imm, is_load, is_jalr, is_s, is_b, is_u, is_jal, is_i;
  logic illegal, use_rs1, use_rs2;
  ctrl_t dec;

  always_comb begin
    is_r    = (opcode == OP_R);
    is_imm  = (opcode == OP_IMM);
    is_load = (opcode == OP_LOAD);
    is_jalr = (opcode == OP_JALR);
    is_s    = (opcode == OP_STORE);
    is_b    = (opcode == OP_BRANCH);
    is_u    = (opcode == OP_LUI) || (opcode == OP_AUIPC);
    is_jal  = (opcode == OP_JAL);
    is_i    = is_imm | is_load | is_jalr;

    illegal = !(is_r | is_i | is_s | is_b | is_u | is_jal);
    if (is_load && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)) illegal = 1'b1;
    if (is_s && funct3 >= 3'b011) illegal = 1'b1;
    if (is_b && (funct3 == 3'b010 || funct3 == 3'b011)) illegal = 1'b1;
    if (is_jalr && funct3 != 3'b000) illegal = 1'b1;
    if (is_r && !(funct7 == 7'b0000000 ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
      illegal = 1'b1;
    // Shift-immediates: slli needs funct7=0, srli/srai allow 0 or 0100000.
    if (is_imm && funct3 == 3'b001 && funct7 != 7'b0000000) illegal = 1'b1;
    if (is_imm && funct3 == 3'b101 && !(funct7 == 7'b0000000 || funct7 == 7'b0100000))
      illegal = 1'b1;

    use_rs1 = is_r | is_s | is_b | is_i;
    use_rs2 = is_r | is_s | is_b;

    dec            = '0;
    dec.format     = {is_jal, is_u, is_b, is_s, is_i, is_r};
    dec.opsel      = (is_r | is_i) ? funct3 : 3'b000;
    dec.sub        = is_r ? i_inst[30] : is_b;
    dec.arith      = (is_r | is_i) & (funct3 == 3'b101) & i_inst[30];
    dec.uns        = (is_r | is_i) ? (funct3 == 3'b011) : (is_b & funct3[1]);
    dec.rd_wen     = !(is_s | is_b) & !illegal;
    dec.mem_wen    = is_s & !illegal;
    dec.mem_to_reg = is_load;
    dec.alu_src_2  = is_r | is_b;
    dec.alu_src1   = is_u;
    dec.u_load0    = is_u & i_inst[5];
    dec.sbhw_sel   = is_s ? funct3[1:0] : 2'b00;
    dec.lbhw_sel   = is_load ? funct3[1:0] : 2'b00;
    dec.l_unsigned = is_load & funct3[2];
    dec.is_branch  = is_b & !illegal;
    dec.is_jal     = is_jal & !illegal;
    dec.is_jalr    = is_jalr & !illegal;
    dec.is_jump    = (is_jal | is_jalr) & !illegal;
    dec.illegal    = illegal;
  end

  logic [LOAD_USE_LAT-1:0]      sb_v;
  logic [LOAD_USE_LAT-1:0][4:0] sb_rd;
  logic hit, hazard, push_v;

  always_comb begin
    hit = 1'b0;
    for (int unsigned k = 0; k < LOAD_USE_LAT; k++) begin
      if (sb_v[k] && ((use_rs1 && rs1 != 5'd0 && sb_rd[k] == rs1) ||
                      (use_rs2 && rs2 != 5'd0 && sb_rd[k] == rs2)))
        hit = 1'b1;
    end
  end

  assign hazard  = i_valid & hit;
  assign o_ready = i_ex_ready & ~hazard & ~i_rst;
  assign push_v  = i_valid & ~hazard & is_load & ~illegal & (rd != 5'd0);

  logic        valid_q;
  logic [31:0] inst_q;
  ctrl_t       ctrl_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      ctrl_q  <= '0;
      sb_v    <= '0;
      sb_rd   <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
      sb_v    <= '0;
    end else if (i_ex_ready) begin
      valid_q  <= i_valid & ~hazard;
      inst_q   <= i_inst;
      ctrl_q   <= dec;
      sb_v[0]  <= push_v;
      sb_rd[0] <= rd;
      for (int unsigned k = 1; k < LOAD_USE_LAT; k++) begin
        sb_v[k]  <= sb_v[k-1];
        sb_rd[k] <= sb_rd[k-1];
      end
    end
  end

  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      stall_cnt <= '0;
    else if (hazard && i_ex_ready && !i_flush && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign o_valid      = valid_q;
  assign o_inst       = inst_q;
  assign o_format     = ctrl_q.format;
  assign o_opsel      = ctrl_q.opsel;
  assign o_sub        = ctrl_q.sub;
  assign o_unsigned   = ctrl_q.uns;
  assign o_arith      = ctrl_q.arith;
  assign o_rd_wen     = ctrl_q.rd_wen;
  assign o_mem_wen    = ctrl_q.mem_wen;
  assign o_mem_to_reg = ctrl_q.mem_to_reg;
  assign o_alu_src_2  = ctrl_q.alu_src_2;
  assign o_alu_src1   = ctrl_q.alu_src1;
  assign o_u_load0    = ctrl_q.u_load0;
  assign o_sbhw_sel   = ctrl_q.sbhw_sel;
  assign o_lbhw_sel   = ctrl_q.lbhw_sel;
  assign o_l_unsigned = ctrl_q.l_unsigned;
  assign o_is_branch  = ctrl_q.is_branch;
  assign o_is_jal     = ctrl_q.is_jal;
  assign o_is_jalr    = ctrl_q.is_jalr;
  assign o_is_jump    = ctrl_q.is_jump;
  assign o_illegal    = ctrl_q.illegal;
  assign o_stall_cnt  = stall_cnt;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Directed bench for id_ctrl_pipe: three instances (LAT 1/2/3, counter widths 16/16/2) share one
// stimulus stream and are checked every cycle against a register-availability model.
module tb_id_ctrl_pipe;
  localparam int NI = 3;
  localparam int unsigned LATS [NI] = '{1, 2, 3};
  localparam int unsigned CMAX [NI] = '{65535, 65535, 3};

  localparam logic [31:0] ADD3  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] LW5   = 32'h0000A283; // lw  x5,0(x1)
  localparam logic [31:0] ADD6  = 32'h00728333; // add x6,x5,x7
  localparam logic [31:0] LW0   = 32'h0000A003; // lw  x0,0(x1)
  localparam logic [31:0] USE0  = 32'h00000333; // add x6,x0,x0

  // Packed decode bit positions (MSB first): format, opsel, sub, uns, arith, rd_wen, mem_wen,
  // mem_to_reg, alu_src_2, alu_src1, u_load0, sbhw, lbhw, l_uns, branch, jal, jalr, jump, illegal.
  localparam int B_SUB = 18, B_RDW = 15, B_MEMW = 14, B_SRC2 = 12, B_ILL = 0;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_inst = '0;
  logic        i_valid = 1'b0, i_ex_ready = 1'b0, i_flush = 1'b0;

  always #5 i_clk = ~i_clk;

  logic        o_ready_a [NI];
  logic        o_valid_a [NI];
  logic [31:0] o_inst_a  [NI];
  logic [27:0] dec_a     [NI];
  logic [15:0] cnt_a     [NI];

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int unsigned CW = (g == 2) ? 2 : 16;
    logic [5:0] fmt; logic [2:0] opsel;
    logic sub, uns, arith, rd_wen, mem_wen, m2r, src2, src1, ul0;
    logic [1:0] sbhw, lbhw;
    logic luns, br, jal, jalr, jump, ill, rdy, vld;
    logic [31:0] inst;
    logic [CW-1:0] cnt;

    id_ctrl_pipe #(.LOAD_USE_LAT(LATS[g]), .CNT_W(CW)) u_dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_inst(i_inst), .i_valid(i_valid), .o_ready(rdy),
      .i_ex_ready(i_ex_ready), .i_flush(i_flush), .o_valid(vld), .o_inst(inst),
      .o_format(fmt), .o_opsel(opsel), .o_sub(sub), .o_unsigned(uns), .o_arith(arith),
      .o_rd_wen(rd_wen), .o_mem_wen(mem_wen), .o_mem_to_reg(m2r), .o_alu_src_2(src2),
      .o_alu_src1(src1), .o_u_load0(ul0), .o_sbhw_sel(sbhw), .o_lbhw_sel(lbhw),
      .o_l_unsigned(luns), .o_is_branch(br), .o_is_jal(jal), .o_is_jalr(jalr),
      .o_is_jump(jump), .o_illegal(ill), .o_stall_cnt(cnt)
    );

    assign o_ready_a[g] = rdy;
    assign o_valid_a[g] = vld;
    assign o_inst_a[g]  = inst;
    assign dec_a[g] = {fmt, opsel, sub, uns, arith, rd_wen, mem_wen, m2r, src2, src1, ul0,
                       sbhw, lbhw, luns, br, jal, jalr, jump, ill};
    assign cnt_a[g] = 16'(cnt);
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_ill(input logic [31:0] x);
    logic [6:0] op = x[6:0];
    logic [2:0] f3 = x[14:12];
    logic [6:0] f7 = x[31:25];
    case (op)
      7'h33: return !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      7'h13: begin
        if (f3 == 3'd1) return f7 != 7'h00;
        if (f3 == 3'd5) return !(f7 == 7'h00 || f7 == 7'h20);
        return 1'b0;
      end
      7'h03: return f3 inside {3'd3, 3'd6, 3'd7};
      7'h23: return f3 >= 3'd3;
      7'h63: return f3 inside {3'd2, 3'd3};
      7'h67: return f3 != 3'd0;
      7'h37, 7'h17, 7'h6f: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [27:0] ref_dec(input logic [31:0] x);
    logic [6:0] op = x[6:0];
    logic [2:0] f3 = x[14:12];
    bit r  = (op == 7'h33);
    bit i  = (op == 7'h13 || op == 7'h03 || op == 7'h67);
    bit s  = (op == 7'h23);
    bit b  = (op == 7'h63);
    bit u  = (op == 7'h37 || op == 7'h17);
    bit j  = (op == 7'h6f);
    bit ld = (op == 7'h03);
    bit jr = (op == 7'h67);
    bit il = ref_ill(x);
    logic [27:0] d = '0;
    d[27:22] = {j, u, b, s, i, r};
    if (r || i) d[21:19] = f3;
    d[18] = r ? x[30] : b;
    d[17] = (r || i) ? (f3 == 3'd3) : (b && f3[1]);
    d[16] = (r || i) && f3 == 3'd5 && x[30];
    d[15] = !(s || b) && !il;
    d[14] = s && !il;
    d[13] = ld;
    d[12] = r || b;
    d[11] = u;
    d[10] = u && x[5];
    if (s)  d[9:8] = f3[1:0];
    if (ld) d[7:6] = f3[1:0];
    d[5] = ld && f3[2];
    d[4] = b && !il;
    d[3] = j && !il;
    d[2] = jr && !il;
    d[1] = (j || jr) && !il;
    d[0] = il;
    return d;
  endfunction

  // Each register records the step number until which a load result is unavailable.
  bit          mv    [NI];
  logic [31:0] minst [NI];
  int unsigned busy  [NI][32];
  int unsigned nstep [NI];
  int unsigned mcnt  [NI];

  function automatic bit ref_hazard(input int g, input logic [31:0] x, input logic v);
    logic [6:0] op = x[6:0];
    bit two = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    bit one = two || (op == 7'h13 || op == 7'h03 || op == 7'h67);
    logic [4:0] a = x[19:15];
    logic [4:0] b = x[24:20];
    return v && ((one && a != 5'd0 && nstep[g] < busy[g][a]) ||
                 (two && b != 5'd0 && nstep[g] < busy[g][b]));
  endfunction

  function automatic bit ref_pushes(input logic [31:0] x);
    return x[6:0] == 7'h03 && x[11:7] != 5'd0 && !ref_ill(x);
  endfunction

  always @(posedge i_clk) begin
    for (int g = 0; g < NI; g++) begin
      if (i_rst) begin
        mv[g] <= 1'b0; minst[g] <= '0; nstep[g] <= 0; mcnt[g] <= 0;
        for (int r = 0; r < 32; r++) busy[g][r] <= 0;
      end else if (i_flush) begin
        mv[g] <= 1'b0;
        for (int r = 0; r < 32; r++) busy[g][r] <= 0;
      end else if (i_ex_ready) begin
        if (ref_hazard(g, i_inst, i_valid) && mcnt[g] < CMAX[g]) mcnt[g] <= mcnt[g] + 1;
        nstep[g] <= nstep[g] + 1;
        mv[g]    <= i_valid && !ref_hazard(g, i_inst, i_valid);
        minst[g] <= i_inst;
        if (i_valid && !ref_hazard(g, i_inst, i_valid) && ref_pushes(i_inst))
          busy[g][i_inst[11:7]] <= nstep[g] + 1 + LATS[g];
      end
    end
  end

  always @(negedge i_clk) begin
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("u%0d.valid", g), 32'(o_valid_a[g]), 32'(mv[g]));
      chk($sformatf("u%0d.ready", g), 32'(o_ready_a[g]),
          32'(i_ex_ready && !i_rst && !ref_hazard(g, i_inst, i_valid)));
      chk($sformatf("u%0d.stall_cnt", g), 32'(cnt_a[g]), mcnt[g]);
      if (mv[g]) begin
        chk($sformatf("u%0d.inst", g), o_inst_a[g], minst[g]);
        chk($sformatf("u%0d.decode", g), 32'(dec_a[g]), 32'(ref_dec(minst[g])));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [31:0] x, input logic v, input logic er, input logic fl);
    i_inst = x; i_valid = v; i_ex_ready = er; i_flush = fl;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive('0, 1'b0, 1'b1, 1'b0);
    repeat (n) tick();
  endtask

  typedef struct {
    logic [31:0] inst;
    logic        ill;
    logic        rdw;
    logic        memw;
  } ivec_t;

  ivec_t vecs [10] = '{
    '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0},
    '{32'h4020C1B3, 1'b1, 1'b0, 1'b0},  // xor with sub-style funct7
    '{32'h000110E7, 1'b1, 1'b0, 1'b0},  // jalr funct3=001
    '{32'h40209193, 1'b1, 1'b0, 1'b0},  // slli with funct7=0100000
    '{32'h0020A223, 1'b0, 1'b0, 1'b1},  // sw
    '{32'h00208463, 1'b0, 1'b0, 1'b0},  // beq
    '{32'h123452B7, 1'b0, 1'b1, 1'b0},  // lui
    '{32'h000000EF, 1'b0, 1'b1, 1'b0},  // jal
    '{32'h4020D193, 1'b0, 1'b1, 1'b0},  // srai
    '{32'h0000C283, 1'b0, 1'b1, 1'b0}   // lbu
  };

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with ex_ready high: o_ready must still be 0.
    i_rst = 1'b1;
    drive(ADD3, 1'b1, 1'b1, 1'b0);
    tick(); tick();
    chk("rst.ready", 32'(o_ready_a[0]), 32'd0);
    chk("rst.valid", 32'(o_valid_a[0]), 32'd0);
    chk("rst.inst", o_inst_a[0], 32'd0);
    chk("rst.decode", 32'(dec_a[0]), 32'd0);
    chk("rst.cnt", 32'(cnt_a[0]), 32'd0);

    // add x3,x1,x2 issues with one cycle of latency.
    i_rst = 1'b0;
    tick();
    chk("add.valid", 32'(o_valid_a[0]), 32'd1);
    chk("add.format", 32'(dec_a[0][27:22]), 32'b000001);
    chk("add.src2", 32'(dec_a[0][B_SRC2]), 32'd1);
    chk("add.rd_wen", 32'(dec_a[0][B_RDW]), 32'd1);
    chk("add.sub", 32'(dec_a[0][B_SUB]), 32'd0);

    // lw x5 then dependent add: LAT1 one bubble, LAT2 two bubbles.
    drive(LW5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(ADD6, 1'b1, 1'b1, 1'b0);
    #1 chk("lu1.ready_c1", 32'(o_ready_a[0]), 32'd0);
    tick();
    chk("lu1.bubble", 32'(o_valid_a[0]), 32'd0);
    chk("lu1.cnt", 32'(cnt_a[0]), 32'd1);
    #1 chk("lu1.ready_c2", 32'(o_ready_a[0]), 32'd1);
    chk("lu2.ready_c2", 32'(o_ready_a[1]), 32'd0);
    tick();
    chk("lu1.issue", o_inst_a[0], ADD6);
    chk("lu2.bubble2", 32'(o_valid_a[1]), 32'd0);
    chk("lu2.cnt", 32'(cnt_a[1]), 32'd2);
    tick();
    chk("lu2.issue", 32'(o_valid_a[1]), 32'd1);
    idle(4);

    // Load to x0 never creates a hazard.
    drive(LW0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(USE0, 1'b1, 1'b1, 1'b0);
    #1 chk("x0.ready_lat2", 32'(o_ready_a[1]), 32'd1);
    chk("x0.ready_lat3", 32'(o_ready_a[2]), 32'd1);
    tick();
    chk("x0.issue", 32'(o_valid_a[1]), 32'd1);
    idle(4);

    // Backpressure: register and scoreboard frozen for 3 cycles.
    drive(LW5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      #1 chk("bp.ready", 32'(o_ready_a[0]), 32'd0);
      chk("bp.hold_inst", o_inst_a[0], LW5);
      chk("bp.hold_valid", 32'(o_valid_a[0]), 32'd1);
      tick();
    end
    drive(ADD6, 1'b1, 1'b1, 1'b0);
    #1 chk("bp.still_hazard", 32'(o_ready_a[0]), 32'd0);
    tick();
    chk("bp.bubble", 32'(o_valid_a[0]), 32'd0);
    tick(); tick();
    chk("bp.cnt_lat1", 32'(cnt_a[0]), 32'd2);
    chk("bp.cnt_lat2", 32'(cnt_a[1]), 32'd4);
    chk("sat.cnt_w2", 32'(cnt_a[2]), 32'd3);
    idle(4);

    // Flush during a load-use stall clears the scoreboard and does not count a stall.
    drive(LW5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(ADD6, 1'b1, 1'b1, 1'b1);
    tick();
    chk("fl.valid", 32'(o_valid_a[0]), 32'd0);
    chk("fl.cnt", 32'(cnt_a[0]), 32'd2);
    drive(ADD6, 1'b1, 1'b1, 1'b0);
    #1 chk("fl.ready_lat3", 32'(o_ready_a[2]), 32'd1);
    tick();
    chk("fl.issue", o_inst_a[2], ADD6);
    // Flush drops an instruction even when o_ready=1.
    drive(ADD3, 1'b1, 1'b1, 1'b1);
    tick();
    chk("fl.drop", 32'(o_valid_a[0]), 32'd0);
    idle(4);

    // Legal and illegal encodings.
    foreach (vecs[k]) begin
      drive(vecs[k].inst, 1'b1, 1'b1, 1'b0);
      tick();
      chk($sformatf("enc%0d.illegal", k), 32'(dec_a[0][B_ILL]), 32'(vecs[k].ill));
      chk($sformatf("enc%0d.rd_wen", k), 32'(dec_a[0][B_RDW]), 32'(vecs[k].rdw));
      chk($sformatf("enc%0d.mem_wen", k), 32'(dec_a[0][B_MEMW]), 32'(vecs[k].memw));
    end
    idle(4);

    // Reset mid-stall drops the held instruction and clears the scoreboard.
    drive(LW5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(ADD6, 1'b1, 1'b1, 1'b0);
    i_rst = 1'b1;
    tick();
    chk("rst2.valid", 32'(o_valid_a[0]), 32'd0);
    chk("rst2.cnt", 32'(cnt_a[2]), 32'd0);
    i_rst = 1'b0;
    #1 chk("rst2.ready", 32'(o_ready_a[2]), 32'd1);
    tick();
    chk("rst2.issue", o_inst_a[0], ADD6);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
